mult_share_arb: RTL
===================

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 The block SHALL have one parameter: MULT_LAT, default 6, the number of cycles from the multiplier sampling start=1 to its product output being valid.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high (clk, rst).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0 / req1  input  1  request from requester 0 / 1, held until its done pulse.
REQ-006 a0, b0 / a1, b1  input  4 each  multiplier and multiplicand operands of requester 0 / 1.
REQ-007 done0 / done1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-008 result  output  8  registered product of the most recently completed operation.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 mult_start  output  1  one-cycle start pulse to the shared sequential 4x4 multiplier.
REQ-011 mult_multiplier, mult_multiplicand  output  4 each  latched operands to the multiplier.
REQ-012 mult_product  input  8  product from the multiplier.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-014 In IDLE with any req high, the block SHALL grant one requester, latch that requester's operands into the mult_* registers, and move to ISSUE. With no req high it SHALL stay in IDLE.
REQ-015 When only one req is high, the grant SHALL go to that requester. When both are high, the grant SHALL go to the requester not served last (round-robin).
REQ-016 In ISSUE, mult_start SHALL be 1 for exactly one cycle, a wait counter SHALL be loaded with MULT_LAT, and the FSM SHALL move to WAIT.
REQ-017 In WAIT, the counter SHALL decrement every cycle. When the counter reaches 1, the FSM SHALL capture mult_product into result on that edge and move to DONE.
REQ-018 In DONE, the granted requester's done SHALL be 1 for one cycle, the last-served pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-019 Latency: with the request sampled in cycle 0, mult_start SHALL be high in cycle 1 and done SHALL be high in cycle MULT_LAT+2 (cycle 8 at the default).
REQ-020 The mult_* operands SHALL stay stable from ISSUE through DONE. Operand changes on the a/b inputs after the grant SHALL have no effect.
REQ-021 Requests arriving while busy SHALL be ignored until the next IDLE. A req still high in the cycle after done SHALL count as a new request.
REQ-022 result SHALL hold its value until the next DONE. done0 and done1 SHALL never both be high.
REQ-023 Products SHALL be 8-bit unsigned, with no truncation (for example 15x15 = 225).

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL set: state IDLE; done0, done1, busy and mult_start to 0; result to 0; mult_* operands to 0; counter to 0; last-served pointer to 1, so that req0 wins the first tie.
REQ-025 Reset during ISSUE, WAIT or DONE SHALL abort the operation with no done pulse. Reset SHALL take priority over all other events.

Structure
REQ-026 The shared package mult_arb_pkg SHALL hold the FSM state encoding, the operand width (4), the product width (8) and the MULT_LAT default.
REQ-027 The round-robin selection SHALL be one sub-module, rr_pick2 (inputs: req0, req1, last; outputs: grant_valid, grant_id). The shared multiplier SHALL stay external to this block.

Verification
REQ-028 The bench SHALL model the multiplier with MULT_LAT=6. Scenario: req0 only, a0=3, b0=5 -> mult_start in cycle 1 with operands 3/5; done0 in cycle 8; result=15.
REQ-029 Scenario: after reset, req0 (7x9) and req1 (15x15) rise together -> done0 with result=63 in cycle 8; then req1 granted; done1 with result=225 eight cycles after its grant.
REQ-030 Scenario: both reqs held high continuously -> done pulses alternate 0,1,0,1, and done0 and done1 are never high together.
REQ-031 Scenario: req1 with a1=12, b1=2, and a1 changed to 0 in cycle 2 -> result=24.
REQ-032 Scenario: rst asserted in cycle 4 of a req1 operation -> no done1; busy=0 the next cycle; a following tie is granted to req0.
REQ-033 Scenario: boundary operands 0x13 and 15x0 -> result=0; 15x15 -> result=225; no stale value is shown on result at done.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// mult_arb_pkg: shared sizes, latency default and FSM encoding for the multiplier arbiter
package mult_arb_pkg;
    localparam int OP_W         = 4;
    localparam int PROD_W       = 8;
    localparam int MULT_LAT_DEF = 6;
    localparam int CNT_W        = 8;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: requester handshakes plus the shared-multiplier side of the arbiter
interface mult_share_arb_if;
    import mult_arb_pkg::*;
    logic              req0, req1;
    logic [OP_W-1:0]   a0, b0, a1, b1;
    logic              done0, done1;
    logic [PROD_W-1:0] result;
    logic              busy;
    logic              mult_start;
    logic [OP_W-1:0]   mult_multiplier, mult_multiplicand;
    logic [PROD_W-1:0] mult_product;
    modport slave (
        input  req0, req1, a0, b0, a1, b1, mult_product,
        output done0, done1, result, busy, mult_start, mult_multiplier, mult_multiplicand
    );
    modport master (
        output req0, req1, a0, b0, a1, b1, mult_product,
        input  done0, done1, result, busy, mult_start, mult_multiplier, mult_multiplicand
    );
endinterface

// File: rtl/mult_share_arb_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester not served last wins
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);
    assign grant_valid = req0 | req1;
    assign grant_id    = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one external sequential 4x4 multiplier between two requesters
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input logic clk,
    input logic rst,
    mult_share_arb_if.slave bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gid_q, gid_d;
    logic              last_q, last_d;
    logic [OP_W-1:0]   mult_multiplier_q, mult_multiplier_d;
    logic [OP_W-1:0]   mult_multiplicand_q, mult_multiplicand_d;
    logic [PROD_W-1:0] result_q, result_d;
    logic              grant_valid, grant_id;

    rr_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // state register; last starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            gid_q               <= 1'b0;
            last_q              <= 1'b1;
            mult_multiplier_q   <= '0;
            mult_multiplicand_q <= '0;
            result_q            <= '0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            gid_q               <= gid_d;
            last_q              <= last_d;
            mult_multiplier_q   <= mult_multiplier_d;
            mult_multiplicand_q <= mult_multiplicand_d;
            result_q            <= result_d;
        end
    end

    // next state: grant and latch operands in IDLE, count down the multiplier latency in WAIT
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        gid_d               = gid_q;
        last_d              = last_q;
        mult_multiplier_d   = mult_multiplier_q;
        mult_multiplicand_d = mult_multiplicand_q;
        result_d            = result_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    gid_d               = grant_id;
                    mult_multiplier_d   = grant_id ? bus.a1 : bus.a0;
                    mult_multiplicand_d = grant_id ? bus.b1 : bus.b0;
                    state_d             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MULT_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = bus.mult_product;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = gid_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state; done goes only to the granted requester
    always_comb begin
        bus.busy              = state_q != S_IDLE;
        bus.mult_start        = state_q == S_ISSUE;
        bus.done0             = (state_q == S_DONE) && !gid_q;
        bus.done1             = (state_q == S_DONE) && gid_q;
        bus.result            = result_q;
        bus.mult_multiplier   = mult_multiplier_q;
        bus.mult_multiplicand = mult_multiplicand_q;
    end
endmodule
